// File: rtl/tick_ctrl.sv
// Tick controller: a prescaled 1 kHz enable with derived 500 Hz and 1 Hz enables,
// a 0..59 seconds counter, and an IDLE/RUN/PAUSE control FSM with single-step.
module tick_ctrl #(
  parameter int DIV_1K  = 100000,
  parameter int DIV_1HZ = 1000
) (
  input  logic       clk_100m,
  input  logic       cr,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       clear,
  output logic       tick_1k,
  output logic       tick_5h,
  output logic       tick_1hz,
  output logic [5:0] sec_cnt,
  output logic       running,
  output logic       paused
);

  localparam int P_W = (DIV_1K > 1) ? $clog2(DIV_1K) : 1;
  localparam int Q_W = (DIV_1HZ > 1) ? $clog2(DIV_1HZ) : 1;
  localparam logic [P_W-1:0] P_LAST   = P_W'(DIV_1K - 1);
  localparam logic [Q_W-1:0] Q_LAST   = Q_W'(DIV_1HZ - 1);
  localparam logic [5:0]     SEC_LAST = 6'd59;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  state_e         state_q, state_d;
  logic [P_W-1:0] p_q, p_d;
  logic [Q_W-1:0] q_q, q_d;
  logic           phase_q, phase_d;
  logic [5:0]     sec_q, sec_d;
  logic           tick_1k_q, tick_1k_d;
  logic           tick_5h_q, tick_5h_d;
  logic           tick_1hz_q, tick_1hz_d;
  logic           running_q, running_d;
  logic           paused_q, paused_d;
  logic           advance_s;
  logic           fire_s;

  function automatic logic [5:0] sec_next(input logic [5:0] s);
    if (s == SEC_LAST) begin
      return 6'd0;
    end else begin
      return s + 6'd1;
    end
  endfunction

  // Next-state: command decode in priority order, then prescaler and tick cascade.
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    q_d        = q_q;
    phase_d    = phase_q;
    sec_d      = sec_q;
    tick_1k_d  = 1'b0;
    tick_5h_d  = 1'b0;
    tick_1hz_d = 1'b0;
    advance_s  = 1'b0;
    fire_s     = 1'b0;

    if (clear) begin
      state_d = S_IDLE;
      p_d     = '0;
      q_d     = '0;
      phase_d = 1'b0;
      sec_d   = 6'd0;
    end else if (stop) begin
      state_d = (state_q == S_RUN) ? S_PAUSE : state_q;
    end else if (start) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          p_d     = '0;
        end
        S_PAUSE: begin
          // The resume edge is itself a counting cycle, so p continues from its frozen value.
          state_d   = S_RUN;
          advance_s = 1'b1;
        end
        S_RUN: begin
          advance_s = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          p_d     = '0;
        end
      endcase
    end else if (step) begin
      fire_s    = (state_q == S_PAUSE);
      advance_s = (state_q == S_RUN);
    end else begin
      advance_s = (state_q == S_RUN);
    end

    if (advance_s) begin
      if (p_q == P_LAST) begin
        p_d    = '0;
        fire_s = 1'b1;
      end else begin
        p_d = p_q + P_W'(1);
      end
    end else begin
      p_d = p_d;
    end

    if (fire_s) begin
      tick_1k_d = 1'b1;
      tick_5h_d = phase_q;
      phase_d   = ~phase_q;
      if (q_q == Q_LAST) begin
        q_d        = '0;
        tick_1hz_d = 1'b1;
        sec_d      = sec_next(sec_q);
      end else begin
        q_d = q_q + Q_W'(1);
      end
    end else begin
      q_d = q_d;
    end

    running_d = (state_d == S_RUN);
    paused_d  = (state_d == S_PAUSE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_100m) begin
    if (cr) begin
      state_q    <= S_IDLE;
      p_q        <= '0;
      q_q        <= '0;
      phase_q    <= 1'b0;
      sec_q      <= 6'd0;
      tick_1k_q  <= 1'b0;
      tick_5h_q  <= 1'b0;
      tick_1hz_q <= 1'b0;
      running_q  <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      q_q        <= q_d;
      phase_q    <= phase_d;
      sec_q      <= sec_d;
      tick_1k_q  <= tick_1k_d;
      tick_5h_q  <= tick_5h_d;
      tick_1hz_q <= tick_1hz_d;
      running_q  <= running_d;
      paused_q   <= paused_d;
    end
  end

  assign tick_1k  = tick_1k_q;
  assign tick_5h  = tick_5h_q;
  assign tick_1hz = tick_1hz_q;
  assign sec_cnt  = sec_q;
  assign running  = running_q;
  assign paused   = paused_q;

endmodule

// File: tb/tb_tick_ctrl.sv
// Self-checking bench for tick_ctrl with DIV_1K=5, DIV_1HZ=4: directed scenarios
// plus randomized commands compared against a tick-count based reference model.
module tb_tick_ctrl;

  localparam int DIV_1K  = 5;
  localparam int DIV_1HZ = 4;

  logic       clk_100m = 1'b0;
  logic       cr = 1'b0, start = 1'b0, stop = 1'b0, step = 1'b0, clear = 1'b0;
  logic       tick_1k, tick_5h, tick_1hz, running, paused;
  logic [5:0] sec_cnt;
  logic [10:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state 0=IDLE 1=RUN 2=PAUSE; ticks counts 1 kHz events since clear.
  int m_state = 0;
  int m_p     = 0;
  int m_ticks = 0;
  bit m_t1k, m_t5h, m_t1hz;

  tick_ctrl #(.DIV_1K(DIV_1K), .DIV_1HZ(DIV_1HZ)) dut (
    .clk_100m(clk_100m), .cr(cr), .start(start), .stop(stop), .step(step), .clear(clear),
    .tick_1k(tick_1k), .tick_5h(tick_5h), .tick_1hz(tick_1hz), .sec_cnt(sec_cnt),
    .running(running), .paused(paused)
  );

  always #5 clk_100m = ~clk_100m;

  assign obs = {tick_1k, tick_5h, tick_1hz, sec_cnt, running, paused};

  function automatic void model_edge(input bit c_cr, input bit c_start, input bit c_stop,
                                     input bit c_step, input bit c_clear);
    bit adv;
    bit fire;
    adv = 1'b0;
    fire = 1'b0;
    m_t1k = 1'b0;
    m_t5h = 1'b0;
    m_t1hz = 1'b0;
    if (c_cr || c_clear) begin
      m_state = 0; m_p = 0; m_ticks = 0;
    end else if (c_stop) begin
      if (m_state == 1) m_state = 2;
    end else if (c_start) begin
      if (m_state == 0) begin
        m_state = 1; m_p = 0;
      end else begin
        m_state = 1; adv = 1'b1;
      end
    end else if (c_step) begin
      fire = (m_state == 2);
      adv  = (m_state == 1);
    end else begin
      adv = (m_state == 1);
    end
    if (adv) begin
      m_p  = (m_p + 1) % DIV_1K;
      fire = (m_p == 0);
    end
    if (fire) begin
      m_ticks++;
      m_t1k  = 1'b1;
      m_t5h  = (m_ticks % 2 == 0);
      m_t1hz = (m_ticks % DIV_1HZ == 0);
    end
  endfunction

  function automatic logic [10:0] model_vec();
    logic [5:0] sec;
    sec = 6'((m_ticks / DIV_1HZ) % 60);
    return {m_t1k, m_t5h, m_t1hz, sec, (m_state == 1), (m_state == 2)};
  endfunction

  task automatic do_edge(input bit c_cr, input bit c_start, input bit c_stop,
                         input bit c_step, input bit c_clear);
    cr = c_cr; start = c_start; stop = c_stop; step = c_step; clear = c_clear;
    @(posedge clk_100m);
    model_edge(c_cr, c_start, c_stop, c_step, c_clear);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      do_edge(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_checks++;
      if (obs !== 11'd0) begin
        n_errors++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, 11'd0);
      end
    end
    do_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== 11'b000_000000_10) begin
      n_errors++;
      $display("FAIL reset_release: got %b expected %b", obs, 11'b000_000000_10);
    end
  endtask

  task automatic test_run_basic();
    logic [31:0] h1k = '0, h5h = '0, h1hz = '0;
    logic [5:0]  sec19 = '0, sec20 = '0;
    do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= 20; k++) begin
      do_edge(1'b0, k == 0, 1'b0, 1'b0, 1'b0);
      h1k[k] = tick_1k; h5h[k] = tick_5h; h1hz[k] = tick_1hz;
      if (k == 19) sec19 = sec_cnt;
      if (k == 20) sec20 = sec_cnt;
    end
    n_checks++;
    if (h1k !== 32'h0010_8420) begin
      n_errors++; $display("FAIL run_tick_1k: got %h expected %h", h1k, 32'h0010_8420);
    end
    n_checks++;
    if (h5h !== 32'h0010_0400) begin
      n_errors++; $display("FAIL run_tick_5h: got %h expected %h", h5h, 32'h0010_0400);
    end
    n_checks++;
    if (h1hz !== 32'h0010_0000) begin
      n_errors++; $display("FAIL run_tick_1hz: got %h expected %h", h1hz, 32'h0010_0000);
    end
    n_checks++;
    if (sec19 !== 6'd0 || sec20 !== 6'd1) begin
      n_errors++; $display("FAIL run_sec: got %0d,%0d expected 0,1", sec19, sec20);
    end
  endtask

  task automatic test_stop_resume();
    logic [31:0] h1k = '0;
    logic p7 = 1'b0, r20 = 1'b0;
    do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= 25; k++) begin
      do_edge(1'b0, (k == 0) || (k == 20), k == 7, 1'b0, 1'b0);
      h1k[k] = tick_1k | tick_5h | tick_1hz;
      if (k == 7) p7 = paused;
      if (k == 20) r20 = running;
    end
    n_checks++;
    if (h1k !== 32'h0080_0020) begin
      n_errors++; $display("FAIL stop_resume_ticks: got %h expected %h", h1k, 32'h0080_0020);
    end
    n_checks++;
    if (p7 !== 1'b1 || r20 !== 1'b1) begin
      n_errors++; $display("FAIL stop_resume_state: got paused=%b running=%b expected 1,1", p7, r20);
    end
  endtask

  task automatic test_step();
    logic [31:0] h1k = '0, h5h = '0, h1hz = '0;
    logic [5:0]  sec12 = '0, sec19 = '0;
    bit s_start, s_stop, s_step;
    do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= 19; k++) begin
      s_start = (k == 0) || (k == 13);
      s_stop  = (k == 3) || (k == 16);
      s_step  = (k == 5) || (k == 7) || (k == 9) || (k == 11) || (k >= 17);
      do_edge(1'b0, s_start, s_stop, s_step, 1'b0);
      h1k[k] = tick_1k; h5h[k] = tick_5h; h1hz[k] = tick_1hz;
      if (k == 12) sec12 = sec_cnt;
      if (k == 19) sec19 = sec_cnt;
    end
    n_checks++;
    if (h1k !== 32'h000E_8AA0) begin
      n_errors++; $display("FAIL step_tick_1k: got %h expected %h", h1k, 32'h000E_8AA0);
    end
    n_checks++;
    if (h5h !== 32'h000A_0880) begin
      n_errors++; $display("FAIL step_tick_5h: got %h expected %h", h5h, 32'h000A_0880);
    end
    n_checks++;
    if (h1hz !== 32'h0008_0800) begin
      n_errors++; $display("FAIL step_tick_1hz: got %h expected %h", h1hz, 32'h0008_0800);
    end
    n_checks++;
    if (sec12 !== 6'd1 || sec19 !== 6'd2) begin
      n_errors++; $display("FAIL step_sec: got %0d,%0d expected 1,2", sec12, sec19);
    end
  endtask

  task automatic test_sec_wrap();
    int n1hz = 0;
    logic [6:0] at1180 = '0, at1200 = '0;
    do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 1200; k++) begin
      do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (tick_1hz === 1'b1) n1hz++;
      if (k == 1180) at1180 = {tick_1hz, sec_cnt};
      if (k == 1200) at1200 = {tick_1hz, sec_cnt};
    end
    n_checks++;
    if (at1180 !== {1'b1, 6'd59} || at1200 !== {1'b1, 6'd0}) begin
      n_errors++;
      $display("FAIL sec_wrap: got %b/%b expected %b/%b", at1180, at1200, {1'b1, 6'd59}, {1'b1, 6'd0});
    end
    n_checks++;
    if (n1hz != 60) begin
      n_errors++; $display("FAIL sec_wrap_count: got %0d expected 60", n1hz);
    end
  endtask

  task automatic test_priority();
    do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= 22; k++) do_edge(1'b0, k == 0, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (obs !== 11'd0) begin
      n_errors++; $display("FAIL clear_stop: got %b expected %b", obs, 11'd0);
    end
    do_edge(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 11'd0) begin
      n_errors++; $display("FAIL step_in_idle: got %b expected %b", obs, 11'd0);
    end
    do_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_edge(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 11'b000_000000_10) begin
      n_errors++; $display("FAIL start_step: got %b expected %b", obs, 11'b000_000000_10);
    end
    do_edge(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (tick_1k !== 1'b0) begin
      n_errors++; $display("FAIL step_in_run: got %b expected 0", tick_1k);
    end
    do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== 11'b100_000000_10) begin
      n_errors++; $display("FAIL resume_tick: got %b expected %b", obs, 11'b100_000000_10);
    end
  endtask

  task automatic test_cr_midcount();
    do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= 4; k++) do_edge(1'b0, k == 0, 1'b0, 1'b0, 1'b0);
    do_edge(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== 11'd0) begin
      n_errors++; $display("FAIL cr_at_last: got %b expected %b", obs, 11'd0);
    end
    do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== 11'd0) begin
      n_errors++; $display("FAIL cr_idle_after: got %b expected %b", obs, 11'd0);
    end
    do_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_edge(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 11'b100_000000_01) begin
      n_errors++; $display("FAIL step_before_cr: got %b expected %b", obs, 11'b100_000000_01);
    end
    do_edge(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 11'd0) begin
      n_errors++; $display("FAIL cr_mid_step: got %b expected %b", obs, 11'd0);
    end
    do_edge(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== 11'b000_000000_10) begin
      n_errors++; $display("FAIL cr_release_start: got %b expected %b", obs, 11'b000_000000_10);
    end
  endtask

  task automatic test_random();
    bit r_cr, r_start, r_stop, r_step, r_clear;
    logic [10:0] exp_v;
    do_edge(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      r_cr    = ($urandom_range(0, 99) < 2);
      r_clear = ($urandom_range(0, 99) < 3);
      r_stop  = ($urandom_range(0, 99) < 8);
      r_start = ($urandom_range(0, 99) < 12);
      r_step  = ($urandom_range(0, 99) < 30);
      do_edge(r_cr, r_start, r_stop, r_step, r_clear);
      exp_v = model_vec();
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL random[%0d]: got %b expected %b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_basic();
    test_stop_resume();
    test_step();
    test_sec_wrap();
    test_priority();
    test_cr_midcount();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tick_ctrl.md
TICK_CTRL -- requirements
Module: tick_ctrl

Interface
REQ-001 SHALL have parameter DIV_1K, default 100000, clk_100m cycles per 1 kHz tick.
REQ-002 SHALL have parameter DIV_1HZ, default 1000, 1 kHz ticks per 1 Hz tick.
REQ-003 SHALL have port clk_100m  input  1  system clock, 100 MHz, sole clock; all logic on its rising edge.
REQ-004 SHALL have port cr  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  level-sampled request: IDLE/PAUSE -> RUN.
REQ-006 SHALL have port stop  input  1  level-sampled request: RUN -> PAUSE.
REQ-007 SHALL have port step  input  1  in PAUSE, issue one 1 kHz tick.
REQ-008 SHALL have port clear  input  1  return to IDLE and zero all counters.
REQ-009 SHALL have port tick_1k  output  1  one-cycle 1 kHz enable pulse.
REQ-010 SHALL have port tick_5h  output  1  one-cycle 500 Hz enable pulse.
REQ-011 SHALL have port tick_1hz  output  1  one-cycle 1 Hz enable pulse.
REQ-012 SHALL have port sec_cnt  output  6  seconds count, 0..59.
REQ-013 SHALL have port running  output  1  high while in RUN.
REQ-014 SHALL have port paused  output  1  high while in PAUSE.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSE; every output registered.
REQ-016 SHALL size prescaler p to ceil(log2(DIV_1K)) bits and sub-counter q to ceil(log2(DIV_1HZ)) bits; all counters wrap to 0, never past their terminal value.
REQ-017 SHALL use input priority clear > stop > start > step when several are high in the same cycle.
REQ-018 SHALL, on clear (any state), go to IDLE and zero p, q, the 5h phase bit and sec_cnt; no tick output asserted in the following cycle.
REQ-019 SHALL, in IDLE with start, go to RUN with p = 0.
REQ-020 SHALL, in RUN, increment p every cycle; when p = DIV_1K-1, set p to 0 and assert tick_1k in the next cycle only, so the first tick_1k occurs DIV_1K cycles after start is sampled and ticks then repeat every DIV_1K cycles.
REQ-021 SHALL toggle the 5h phase bit on each tick_1k event and assert tick_5h with every second tick_1k (2nd, 4th, ... since last clear/reset), in the same cycle.
REQ-022 SHALL advance q on each tick_1k event; when q = DIV_1HZ-1, set q to 0 and assert tick_1hz in the same cycle as that tick_1k.
REQ-023 SHALL increment sec_cnt on each tick_1hz event, wrapping 59 -> 0, with the updated value visible in the same cycle as tick_1hz.
REQ-024 SHALL, in RUN with stop, go to PAUSE, freeze p, q, the 5h phase bit and sec_cnt, and suppress any tick that would have issued on that edge.
REQ-025 SHALL, in PAUSE with start, return to RUN and resume p from its frozen value (no restart).
REQ-026 SHALL, in PAUSE with step, generate one tick_1k event in the next cycle, with the 5h/1hz/sec_cnt side effects of REQ-021..REQ-023; p unchanged.
REQ-027 SHALL, while step is held high, produce one tick per cycle; step SHALL be ignored in IDLE and RUN.
REQ-028 SHALL drive running = (state == RUN) and paused = (state == PAUSE).

Reset
REQ-029 SHALL, with cr high at a clock edge, enter IDLE with p, q, the phase bit and sec_cnt = 0, and all tick outputs, running and paused = 0.
REQ-030 SHALL give cr priority over every other input, including mid-count and mid-step.
REQ-031 SHALL hold reset state while cr stays high, and resume normal operation on the first edge with cr low.

Verification (DIV_1K=5, DIV_1HZ=4)
REQ-032 SHALL cover: start pulse at cycle 0 -> tick_1k at cycles 5, 10, 15, 20; tick_5h at 10, 20; tick_1hz at 20; sec_cnt 1 at 20.
REQ-033 SHALL cover: stop at cycle 7, start at cycle 20 -> no ticks during 8..20; next tick_1k at cycle 23 (p resumed at 2).
REQ-034 SHALL cover: in PAUSE, four single-cycle step pulses -> four tick_1k, two tick_5h, one tick_1hz, sec_cnt +1, p unchanged.
REQ-035 SHALL cover: run 60 s-equivalents (1200 cycles) -> sec_cnt 59 -> 0 wrap on the 60th tick_1hz.
REQ-036 SHALL cover: clear and stop asserted together in RUN -> IDLE, all counters 0; start+step together in PAUSE -> RUN, no step tick.
REQ-037 SHALL cover: cr asserted on the cycle p = DIV_1K-1 -> no tick_1k, all outputs 0 on the next cycle, IDLE.
